rst_gen: RTL and testbench
==========================

RST_GEN -- requirements
Module: rst_gen

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: number of consecutive locked cycles required before system reset release; legal range 2..65535.
REQ-002 Port clk, input, 1: system clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port locked, input, 1: clock-generator lock indication; 1 = clocks stable.
REQ-005 Port soft_rst_req, input, 1: single-cycle request to re-run the reset sequence without lock loss.
REQ-006 Port clr_lock_lost, input, 1: clears the lock_lost sticky flag.
REQ-007 Port sys_rst, output, 1: active-high system reset to downstream logic, registered.
REQ-008 Port rst_done, output, 1: one-cycle pulse marking reset release, registered.
REQ-009 Port lock_lost, output, 1: sticky flag; lock dropped while in RUN.

Function
REQ-010 locked_s denotes the lock signal as seen by the FSM (see Configuration).
REQ-011 FSM states: HOLD, COUNT, RUN; 16-bit counter cnt.
REQ-012 HOLD: sys_rst=1; cnt=0; go to COUNT when locked_s=1, else stay.
REQ-013 COUNT: sys_rst=1; cnt increments by 1 per cycle, starting from 0 on entry.
REQ-014 COUNT with locked_s=0: go to HOLD, cnt cleared; overrides all other COUNT conditions.
REQ-015 COUNT with locked_s=1 and cnt=STABLE_CYCLES-1: go to RUN; COUNT therefore lasts exactly STABLE_CYCLES cycles.
REQ-016 RUN: sys_rst=0; stay while locked_s=1 and soft_rst_req=0.
REQ-017 RUN with locked_s=0: go to HOLD, set lock_lost.
REQ-018 RUN with soft_rst_req=1 and locked_s=1: go to COUNT with cnt=0 (sys_rst reasserted for STABLE_CYCLES cycles).
REQ-019 Lock loss and soft_rst_req in the same cycle: lock loss wins (HOLD, lock_lost set).
REQ-020 soft_rst_req is ignored in HOLD and COUNT.
REQ-021 Latency: locked_s first sampled 1 at edge E -> COUNT from E, sys_rst falls at edge E+STABLE_CYCLES.
REQ-022 rst_done=1 for exactly the first cycle in which sys_rst=0 after each COUNT->RUN transition; 0 otherwise.
REQ-023 sys_rst and rst_done are decoded from registered state only; no combinational path from any input.
REQ-024 lock_lost cleared by clr_lock_lost=1; simultaneous set and clear -> set wins.
REQ-025 cnt never wraps; it is only cleared or incremented below STABLE_CYCLES-1.

Reset
REQ-026 reset=1 at a rising edge: state HOLD, cnt=0, sys_rst=1, rst_done=0, lock_lost=0, synchronizer flops 0.
REQ-027 reset has priority over all inputs; reset asserted mid-COUNT or in RUN returns to HOLD with no rst_done pulse.
REQ-028 After reset deassertion, behaviour follows REQ-012 from the next edge.

Configuration
REQ-029 Macro RST_GEN_LOCK_SYNC_EN defined: locked passes through a two-flop synchronizer; locked_s is the second flop output; all lock-related latencies increase by 2 cycles.
REQ-030 Macro RST_GEN_LOCK_SYNC_EN undefined: locked_s = locked directly; no synchronizer flops exist.

Verification (STABLE_CYCLES=8, macro undefined unless noted)
REQ-031 reset 1 for 3 cycles, locked=1 throughout -> sys_rst=1 for 8 cycles after reset release, then 0; rst_done high exactly 1 cycle.
REQ-032 locked=1 for 5 cycles, 0 for 1 cycle, then 1 -> count restarts; sys_rst falls 8 cycles after the final rise; no early rst_done.
REQ-033 In RUN, locked=0 for 1 cycle -> sys_rst=1 next cycle, lock_lost=1 and stays 1 until clr_lock_lost pulse; lock_lost=1 if clr and set coincide.
REQ-034 In RUN, soft_rst_req pulse -> sys_rst=1 for exactly 8 cycles, rst_done pulse at release, lock_lost unchanged.
REQ-035 In RUN, soft_rst_req=1 and locked=0 same cycle -> HOLD, lock_lost=1; reset asserted at cnt=4 -> HOLD, no rst_done.
REQ-036 RST_GEN_LOCK_SYNC_EN defined, repeat REQ-031 -> sys_rst falls 10 cycles after locked first sampled 1.

Source files
------------

// File: rtl/rst_gen.sv
// Purpose : reset sequencer. Holds sys_rst until the clock generator has been
//           locked for STABLE_CYCLES consecutive cycles, then releases it.
// Latency : sys_rst falls STABLE_CYCLES edges after locked is first sampled high
//           (plus 2 edges when RST_GEN_LOCK_SYNC_EN is defined).
// Backpressure: none; every output is a free-running registered level or pulse.
//
// Ports:
//   clk           system clock, all state changes on its rising edge
//   reset         synchronous active-high reset, priority over every input
//   locked        clock-generator lock indication (1 = clocks stable)
//   soft_rst_req  one-cycle request to re-run the release sequence from RUN
//   clr_lock_lost clears the lock_lost sticky flag
//   sys_rst       registered active-high reset to downstream logic
//   rst_done      registered one-cycle pulse in the first cycle of release
//   lock_lost     sticky flag, set when lock drops while released
//
// Configuration macro: RST_GEN_LOCK_SYNC_EN -- when defined, locked passes
// through a two-flop synchronizer before reaching the sequencer.

module rst_gen #(
   parameter int STABLE_CYCLES = 16   // legal range 2..65535
) (
   input  logic clk,
   input  logic reset,
   input  logic locked,
   input  logic soft_rst_req,
   input  logic clr_lock_lost,
   output logic sys_rst,
   output logic rst_done,
   output logic lock_lost
);

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      COUNT = 2'd1,
      RUN   = 2'd2
   } state_t;

   // Terminal count: COUNT is entered with cnt=0, so leaving at STABLE_CYCLES-1
   // makes the COUNT phase exactly STABLE_CYCLES cycles long.
   localparam logic [15:0] LAST_CNT = 16'(STABLE_CYCLES - 1);

   state_t      state;
   logic [15:0] cnt;
   logic        locked_s;

`ifdef RST_GEN_LOCK_SYNC_EN
   // locked comes from another clock domain's PLL logic; resynchronise it.
   logic sync_q1;
   logic sync_q2;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= locked;
         sync_q2 <= sync_q1;
      end
   end

   assign locked_s = sync_q2;
`else
   assign locked_s = locked;
`endif

   // Outputs are registered alongside the state so that sys_rst and rst_done
   // carry no combinational path from any input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= HOLD;
         cnt       <= 16'd0;
         sys_rst   <= 1'b1;
         rst_done  <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         rst_done <= 1'b0;

         // Clear first; a lock loss set later in this block takes precedence.
         if (clr_lock_lost) begin
            lock_lost <= 1'b0;
         end

         case (state)
            HOLD: begin
               sys_rst <= 1'b1;
               cnt     <= 16'd0;
               if (locked_s) begin
                  state <= COUNT;
               end
            end

            COUNT: begin
               sys_rst <= 1'b1;
               if (!locked_s) begin
                  // Any lock glitch restarts the stability window from scratch.
                  state <= HOLD;
                  cnt   <= 16'd0;
               end else if (cnt == LAST_CNT) begin
                  state    <= RUN;
                  cnt      <= 16'd0;
                  sys_rst  <= 1'b0;
                  rst_done <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            RUN: begin
               if (!locked_s) begin
                  // Lock loss outranks a coincident soft request.
                  state     <= HOLD;
                  cnt       <= 16'd0;
                  sys_rst   <= 1'b1;
                  lock_lost <= 1'b1;
               end else if (soft_rst_req) begin
                  state   <= COUNT;
                  cnt     <= 16'd0;
                  sys_rst <= 1'b1;
               end else begin
                  sys_rst <= 1'b0;
               end
            end

            default: begin
               state   <= HOLD;
               cnt     <= 16'd0;
               sys_rst <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rst_gen.sv
// Purpose : self-checking bench for rst_gen with a scoreboard queue.
// Latency : expected outputs are produced at each rising edge, checked 1 ns later.
// Backpressure: none; the monitor consumes one expected entry per cycle.

module tb_rst_gen;

   localparam int S = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic locked = 1'b0;
   logic soft_rst_req = 1'b0;
   logic clr_lock_lost = 1'b0;
   logic sys_rst;
   logic rst_done;
   logic lock_lost;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic sys_rst;
      logic rst_done;
      logic lock_lost;
   } exp_t;

   exp_t exp_q[$];

   rst_gen #(.STABLE_CYCLES(S)) dut (
      .clk          (clk),
      .reset        (reset),
      .locked       (locked),
      .soft_rst_req (soft_rst_req),
      .clr_lock_lost(clr_lock_lost),
      .sys_rst      (sys_rst),
      .rst_done     (rst_done),
      .lock_lost    (lock_lost)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Released-ness is expressed as a streak of consecutive good (locked, not
   // reset) edges since the last restart; the system is released once that
   // streak exceeds S. A soft request while released restarts the streak at 1.
   int   streak = 0;
   logic m_lost = 1'b0;
   logic dly [2] = '{1'b0, 1'b0};

   always @(posedge clk) begin
      logic ls;
      logic released;
      logic set_lost;
      exp_t e;
`ifdef RST_GEN_LOCK_SYNC_EN
      ls = dly[1];
      dly[1] = dly[0];
      dly[0] = locked;
`else
      ls = locked;
`endif
      if (reset) begin
         streak = 0;
         m_lost = 1'b0;
         dly[0] = 1'b0;
         dly[1] = 1'b0;
      end else begin
         released = (streak > S);
         set_lost = !ls && released;
         if (!ls)
            streak = 0;
         else if (released && soft_rst_req)
            streak = 1;
         else if (streak < S + 2)
            streak = streak + 1;
         if (set_lost)
            m_lost = 1'b1;
         else if (clr_lock_lost)
            m_lost = 1'b0;
      end
      e.sys_rst   = (streak <= S);
      e.rst_done  = (streak == S + 1);
      e.lock_lost = m_lost;
      exp_q.push_back(e);
   end

   // ---------------- monitor ----------------
   task automatic chk(input string name, input logic act, input logic req);
      n_checks++;
      if (act === req)
         n_pass++;
      else
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
         e = exp_q.pop_front();
         chk("sys_rst",   sys_rst,   e.sys_rst);
         chk("rst_done",  rst_done,  e.rst_done);
         chk("lock_lost", lock_lost, e.lock_lost);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic r, input logic lk, input logic s,
                        input logic c, input int n);
      repeat (n) begin
         @(negedge clk);
         reset         = r;
         locked        = lk;
         soft_rst_req  = s;
         clr_lock_lost = c;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with lock held, then release sequence.
      drive(1, 1, 0, 0, 3);
      drive(0, 1, 0, 0, S + 4);

      // Lock glitch during COUNT restarts the window.
      drive(1, 0, 0, 0, 1);
      drive(0, 1, 0, 0, 5);
      drive(0, 0, 0, 0, 1);
      drive(0, 1, 0, 0, S + 4);

      // Lock loss in RUN, sticky flag, clear, then clear coinciding with set.
      drive(0, 0, 0, 0, 1);
      drive(0, 1, 0, 0, S + 4);
      drive(0, 1, 0, 1, 1);
      drive(0, 1, 0, 0, 2);
      drive(0, 0, 0, 1, 1);
      drive(0, 1, 0, 0, S + 4);

      // Soft reset in RUN (lock_lost still set from above), and ignored in COUNT.
      drive(0, 1, 1, 0, 1);
      drive(0, 1, 0, 0, 3);
      drive(0, 1, 1, 0, 1);
      drive(0, 1, 0, 0, S + 4);

      // Soft request coinciding with lock loss, then reset at cnt=4.
      drive(0, 0, 1, 1, 1);
      drive(0, 1, 0, 0, 5);
      drive(1, 1, 0, 0, 1);
      drive(0, 1, 0, 0, S + 4);

      // Randomized traffic, mostly locked so RUN is reached regularly.
      for (int i = 0; i < 2000; i++) begin
         drive($urandom_range(0, 63) == 0,
               $urandom_range(0, 15) != 0,
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) == 0,
               1);
      end

      drive(0, 1, 0, 0, 3);
      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() == 0)
         n_pass++;
      else
         $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
